// File: rtl/m_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// the instruction-fetch (IF) and data-memory (DM) ports, one access in flight.
module m_mem_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_if_req,
    input  logic [31:0] w_if_addr,
    output logic        w_if_gnt,
    output logic        w_if_valid,
    output logic [31:0] w_if_rdata,
    input  logic        w_dm_req,
    input  logic        w_dm_we,
    input  logic [31:0] w_dm_addr,
    input  logic [31:0] w_dm_wdata,
    output logic        w_dm_gnt,
    output logic        w_dm_valid,
    output logic [31:0] w_dm_rdata,
    output logic        w_mem_en,
    output logic        w_mem_we,
    output logic [31:0] w_mem_addr,
    output logic [31:0] w_mem_wdata,
    input  logic [31:0] w_mem_rdata,
    output logic        w_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        r_last;    // 1 = DM was served last
    logic        owner;     // 1 = DM owns the current transaction
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic        grant_if, grant_dm, sample;

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        sample    = 1'b0;
        case (state)
            S_IDLE: begin
                // Grants are combinational, so they are masked while reset is held.
                if (!w_rst) begin
                    if (w_if_req && (!w_dm_req || r_last))
                        grant_if = 1'b1;
                    else if (w_dm_req)
                        grant_dm = 1'b1;
                end
                if (grant_if || grant_dm)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (MEM_LAT == 0) begin
                    sample    = 1'b1;
                    state_nxt = S_RESP;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    sample    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            r_last     <= 1'b1;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            w_if_rdata <= '0;
            w_dm_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (grant_if) begin
                owner   <= 1'b0;
                r_last  <= 1'b0;
                we_q    <= 1'b0;
                addr_q  <= w_if_addr;
                wdata_q <= '0;
            end else if (grant_dm) begin
                owner   <= 1'b1;
                r_last  <= 1'b1;
                we_q    <= w_dm_we;
                addr_q  <= w_dm_addr;
                wdata_q <= w_dm_wdata;
            end
            if (state == S_ISSUE)
                cnt <= 4'(MEM_LAT);
            else if (state == S_WAIT)
                cnt <= cnt - 4'd1;
            if (sample) begin
                if (!owner)
                    w_if_rdata <= w_mem_rdata;
                else
                    w_dm_rdata <= we_q ? '0 : w_mem_rdata;
            end
        end
    end

    assign w_if_gnt    = grant_if;
    assign w_dm_gnt    = grant_dm;
    assign w_busy      = (state != S_IDLE);
    assign w_mem_en    = (state == S_ISSUE);
    assign w_mem_we    = w_mem_en & we_q;
    assign w_mem_addr  = w_mem_en ? addr_q  : '0;
    assign w_mem_wdata = w_mem_en ? wdata_q : '0;
    assign w_if_valid  = (state == S_RESP) && !owner;
    assign w_dm_valid  = (state == S_RESP) && owner;

endmodule
